// File: rtl/clk_divider_pkg.sv
// Shared constants and elaboration-time helpers for the fractional clock divider.
// These helpers compute widths only. They contain no logic.
package clk_divider_pkg;

    localparam int CLK_50M     = 50_000_000;
    localparam int BAUD_9600   = 9_600;
    localparam int BAUD_38400  = 38_400;
    localparam int BAUD_115200 = 115_200;

    // Ceiling log2. Values up to (value-1) fit in the returned number of bits.
    function automatic int clog2(input longint value);
        int     width;
        longint v;
        width = 0;
        v     = value - 1;
        while (v > 0) begin
            width = width + 1;
            v     = v >> 1;
        end
        return width;
    endfunction

    // The largest intermediate value is (FBASE - 1) + 2*FOUT. That value must fit.
    function automatic int acc_width(input longint fbase, input longint fout);
        return clog2(fbase + 2 * fout);
    endfunction

endpackage

// File: rtl/clk_divider.sv
// Fractional clock divider: phase accumulator gives exact long-term FOUT from FBASE; out and tick are
// registered and change on the same edge as the accumulator wrap; en=0 freezes phase (no backpressure).
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int FBASE = CLK_50M,
    parameter int FOUT  = BAUD_9600
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic out,
    output logic tick
);

    localparam int            AW   = acc_width(FBASE, FOUT);
    localparam logic [AW-1:0] STEP = AW'(2 * FOUT);
    localparam logic [AW-1:0] MOD  = AW'(FBASE);

    generate
        if (FBASE <= 0 || FOUT <= 0 || 2 * FOUT > FBASE) begin : g_param_check
            $error("clk_divider: need FBASE > 0, FOUT > 0 and 2*FOUT <= FBASE (FBASE=%0d FOUT=%0d)",
                   FBASE, FOUT);
        end
    endgenerate

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic          wrap;

    // AW holds acc + STEP without overflow. One wrap per edge is at most one toggle, because STEP <= MOD.
    assign sum  = acc + STEP;
    assign wrap = (sum >= MOD);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            out  <= 1'b0;
            tick <= 1'b0;
        end else if (en) begin
            acc  <= wrap ? (sum - MOD) : sum;
            out  <= wrap ? ~out : out;
            tick <= wrap & ~out;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: five parameterisations share one rst/en stream and are checked every cycle
// against an arithmetic toggle-count model, plus literal expectations for edges, counts and half-periods.
module tb_clk_divider;

    localparam int NI = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic [NI-1:0] out_v;
    logic [NI-1:0] tick_v;

    always #5 clk = ~clk;

    clk_divider #(.FBASE(50_000_000), .FOUT(115_200)) u0 (.clk(clk), .rst(rst), .en(en), .out(out_v[0]), .tick(tick_v[0]));
    clk_divider #(.FBASE(50_000_000), .FOUT(38_400))  u1 (.clk(clk), .rst(rst), .en(en), .out(out_v[1]), .tick(tick_v[1]));
    clk_divider #(.FBASE(50_000_000), .FOUT(9_600))   u2 (.clk(clk), .rst(rst), .en(en), .out(out_v[2]), .tick(tick_v[2]));
    clk_divider #(.FBASE(100),        .FOUT(10))      u3 (.clk(clk), .rst(rst), .en(en), .out(out_v[3]), .tick(tick_v[3]));
    clk_divider #(.FBASE(4),          .FOUT(2))       u4 (.clk(clk), .rst(rst), .en(en), .out(out_v[4]), .tick(tick_v[4]));

    // Model parameters: STEP = 2*FOUT and MOD = FBASE for each instance.
    longint step_m [NI] = '{230_400, 76_800, 19_200, 20, 4};
    longint mod_m  [NI] = '{50_000_000, 50_000_000, 50_000_000, 100, 4};

    longint n_m      [NI] = '{default: 0};
    longint tog      [NI] = '{default: 0};
    longint ticks    [NI] = '{default: 0};
    longint first_r  [NI] = '{default: 0};
    longint hp_min   [NI] = '{default: 0};
    longint hp_max   [NI] = '{default: 0};
    longint hp_wall  [NI] = '{default: 0};
    longint last_n   [NI] = '{default: 0};
    longint last_cyc [NI] = '{default: 0};
    logic   prev_out [NI] = '{default: 1'b0};
    longint cyc = 0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int idx, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s[%0d] got=%0d want=%0d (cycle %0d)", name, idx, act, exp, cyc);
        end
    endtask

    // Toggles completed after n enabled edges: floor(n*2*FOUT/FBASE).
    function automatic longint toggles(input int i, input longint n);
        return (n * step_m[i]) / mod_m[i];
    endfunction

    // Advance one clock, then compare every instance against the model and collect timing statistics.
    task automatic step();
        longint t_now;
        longint t_prev;
        logic   e_out;
        logic   e_tick;
        longint hp;
        for (int i = 0; i < NI; i++) begin
            if (rst)     n_m[i] = 0;
            else if (en) n_m[i] = n_m[i] + 1;
        end
        @(negedge clk);
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            t_now  = toggles(i, n_m[i]);
            t_prev = (n_m[i] > 0) ? toggles(i, n_m[i] - 1) : 0;
            e_out  = t_now[0];
            e_tick = !rst && en && (t_now != t_prev) && t_now[0];
            chk("out_vs_model", i, longint'(out_v[i]), longint'(e_out));
            chk("tick_vs_model", i, longint'(tick_v[i]), longint'(e_tick));

            if (rst) begin
                tog[i] = 0; ticks[i] = 0; first_r[i] = 0;
                hp_min[i] = 64'h7fff_ffff; hp_max[i] = 0;
                last_n[i] = 0; last_cyc[i] = cyc;
            end else if (out_v[i] != prev_out[i]) begin
                tog[i] = tog[i] + 1;
                hp = n_m[i] - last_n[i];
                if (hp < hp_min[i]) hp_min[i] = hp;
                if (hp > hp_max[i]) hp_max[i] = hp;
                hp_wall[i]  = cyc - last_cyc[i];
                last_n[i]   = n_m[i];
                last_cyc[i] = cyc;
                if (out_v[i] && first_r[i] == 0) first_r[i] = n_m[i];
            end
            if (!rst && tick_v[i]) ticks[i] = ticks[i] + 1;
            prev_out[i] = out_v[i];
        end
    endtask

    longint exp_first [NI] = '{218, 652, 2605, 5, 1};
    longint exp_tog   [NI] = '{46, 15, 3, 2000, 10000};
    longint exp_ticks [NI] = '{23, 8, 2, 1000, 5000};
    longint hp_lo     [NI] = '{217, 651, 2604, 5, 1};
    longint hp_hi     [NI] = '{218, 652, 2605, 5, 1};

    initial begin
        int cnt;

        // Reset with en high: reset must win.
        rst = 1'b1; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                chk("reset_out", i, longint'(out_v[i]), 0);
                chk("reset_tick", i, longint'(tick_v[i]), 0);
            end
        end

        rst = 1'b0; en = 1'b1;
        for (int k = 0; k < 10000; k++) step();

        for (int i = 0; i < NI; i++) begin
            chk("first_rise_edge", i, first_r[i], exp_first[i]);
            chk("toggle_count", i, tog[i], exp_tog[i]);
            chk("tick_count", i, ticks[i], exp_ticks[i]);
            chk("half_period_min_ok", i, longint'(hp_min[i] >= hp_lo[i]), 1);
            chk("half_period_max_ok", i, longint'(hp_max[i] <= hp_hi[i]), 1);
        end
        chk("model_pin_115200", 0, toggles(0, 10000), 46);
        chk("model_pin_9600", 2, toggles(2, 10000), 3);

        // Freeze mid half-period on FBASE=100/FOUT=10: after 7 edges out=1 and acc=40.
        rst = 1'b1; step();
        rst = 1'b0; en = 1'b1;
        for (int k = 0; k < 7; k++) step();
        chk("pre_freeze_out", 3, longint'(out_v[3]), 1);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("frozen_out", 3, longint'(out_v[3]), 1);
            chk("frozen_tick", 3, longint'(tick_v[3]), 0);
            chk("frozen_acc", 3, longint'(u3.acc), 40);
        end
        en = 1'b1;
        cnt = 0;
        while (out_v[3] == 1'b1 && cnt < 20) begin step(); cnt++; end
        chk("resume_edges_to_fall", 3, cnt, 3);
        chk("stretched_half_period", 3, hp_wall[3], 12);

        // Reset while out is high, with en held high.
        cnt = 0;
        while (out_v[3] == 1'b0 && cnt < 20) begin step(); cnt++; end
        chk("out_high_before_rst", 3, longint'(out_v[3]), 1);
        rst = 1'b1; en = 1'b1;
        step();
        chk("rst_mid_out", 3, longint'(out_v[3]), 0);
        chk("rst_mid_tick", 3, longint'(tick_v[3]), 0);
        chk("rst_mid_acc", 3, longint'(u3.acc), 0);
        rst = 1'b0;
        cnt = 0;
        while (out_v[3] == 1'b0 && cnt < 20) begin step(); cnt++; end
        chk("edges_to_rise_after_rst", 3, cnt, 5);
        chk("tick_on_rise_after_rst", 3, longint'(tick_v[3]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
